// File: rtl/icache_pkg.sv
// ---------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the direct-mapped instruction cache: the refill
// FSM state encoding, default geometry, and the address-field widths that
// follow from that geometry.
// ---------------------------------------------------------------------------
package icache_pkg;

    localparam int unsigned XLEN            = 32;

    // Default geometry; the top level may override it through its parameters.
    localparam int unsigned DEF_SETS        = 16;
    localparam int unsigned DEF_BLOCK_WORDS = 4;
    localparam logic [XLEN-1:0] DEF_INSTR_NOP = 32'h0000_0013;

    // Address split for the default geometry: | tag | index | word | 2'b00 |
    localparam int unsigned DEF_WO_W   = $clog2(DEF_BLOCK_WORDS);
    localparam int unsigned DEF_IX_W   = $clog2(DEF_SETS);
    localparam int unsigned DEF_LINE_W = XLEN - 2 - DEF_WO_W;
    localparam int unsigned DEF_TAG_W  = DEF_LINE_W - DEF_IX_W;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

endpackage : icache_pkg

// File: rtl/icache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// icache_refill_ctrl
// Refill sequencer for the instruction cache. On a miss it latches the
// line address and walks the line word 0..BLOCK_WORDS-1 over a req/ready
// handshake, producing the array write strobes as each word is accepted.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   req_miss_i           qualified miss this cycle (only acted on in IDLE)
//   miss_line_i          {tag, index} of the missing address
//   invalidate_i         fence.i pulse; aborts validation of the line in flight
//   mem_ready_i          memory accepted the current word
//   busy_o               refill in progress (state REFILL)
//   mem_req_o/mem_addr_o refill request and word-aligned address
//   fill_line_o          {tag, index} being refilled
//   fill_word_o          word offset being refilled
//   data_we_o            write the accepted word into the data array
//   tag_we_o             write the line tag (last word accepted)
//   valid_set_o          mark the line valid (last word, not aborted)
// ---------------------------------------------------------------------------
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int unsigned WO_W   = DEF_WO_W,
    parameter int unsigned LINE_W = DEF_LINE_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_miss_i,
    input  logic [LINE_W-1:0] miss_line_i,
    input  logic              invalidate_i,
    input  logic              mem_ready_i,
    output logic              busy_o,
    output logic              mem_req_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [LINE_W-1:0] fill_line_o,
    output logic [WO_W-1:0]   fill_word_o,
    output logic              data_we_o,
    output logic              tag_we_o,
    output logic              valid_set_o
);

    state_e            state_q, state_d;
    logic [WO_W-1:0]   word_cnt_q, word_cnt_d;
    logic [LINE_W-1:0] miss_line_q, miss_line_d;
    logic              abort_q, abort_d;

    // Next-state and write-strobe logic.
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        miss_line_d = miss_line_q;
        abort_d     = abort_q;
        data_we_o   = 1'b0;
        tag_we_o    = 1'b0;
        valid_set_o = 1'b0;

        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (req_miss_i) begin
                    miss_line_d = miss_line_i;
                    word_cnt_d  = '0;
                    state_d     = REFILL;
                end
            end
            REFILL: begin
                // No cancel on the memory side: the line is always finished,
                // an invalidate only stops it from becoming valid.
                if (invalidate_i) begin
                    abort_d = 1'b1;
                end
                if (mem_ready_i) begin
                    data_we_o  = 1'b1;
                    word_cnt_d = word_cnt_q + WO_W'(1);
                    if (&word_cnt_q) begin
                        tag_we_o    = 1'b1;
                        valid_set_o = !abort_q && !invalidate_i;
                        abort_d     = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            word_cnt_q  <= '0;
            miss_line_q <= '0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            miss_line_q <= miss_line_d;
            abort_q     <= abort_d;
        end
    end

    // Request outputs come straight from flops, so they are stable until accepted.
    assign busy_o      = (state_q == REFILL);
    assign mem_req_o   = busy_o;
    assign mem_addr_o  = busy_o ? {miss_line_q, word_cnt_q, 2'b00} : '0;
    assign fill_line_o = miss_line_q;
    assign fill_word_o = word_cnt_q;

endmodule : icache_refill_ctrl

// File: rtl/icache_responder.sv
// ---------------------------------------------------------------------------
// icache_responder
// Direct-mapped, read-only instruction cache facing the fetch stage. Hits
// are answered combinationally in the request cycle; misses stall fetch
// while icache_refill_ctrl brings the whole line in from main memory.
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   validReq_i     fetch request valid
//   addr_i         fetch byte address (bits [1:0] ignored)
//   invalidate_i   one-cycle pulse clearing every valid bit
//   ready_o        instr_o holds the word for addr_i this cycle
//   instr_o        instruction word, NOP whenever ready_o is low
//   memReq_o       refill word request
//   memAddr_o      word-aligned refill address
//   memReady_i     memory accepted the request; memData_i valid
//   memData_i      refill data
// ---------------------------------------------------------------------------
module icache_responder
    import icache_pkg::*;
#(
    parameter int unsigned     SETS        = DEF_SETS,
    parameter int unsigned     BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter logic [XLEN-1:0] INSTR_NOP   = DEF_INSTR_NOP
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            validReq_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic            invalidate_i,
    output logic            ready_o,
    output logic [XLEN-1:0] instr_o,
    output logic            memReq_o,
    output logic [XLEN-1:0] memAddr_o,
    input  logic            memReady_i,
    input  logic [XLEN-1:0] memData_i
);

    localparam int unsigned WO_W   = $clog2(BLOCK_WORDS);
    localparam int unsigned IX_W   = $clog2(SETS);
    localparam int unsigned LINE_W = XLEN - 2 - WO_W;
    localparam int unsigned TAG_W  = LINE_W - IX_W;
    localparam int unsigned WORDS  = SETS * BLOCK_WORDS;

    // Storage: only the valid bits are reset.
    logic [SETS-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [XLEN-1:0]  data_q [WORDS];

    // Request address fields.
    logic [WO_W-1:0]   req_word;
    logic [IX_W-1:0]   req_index;
    logic [TAG_W-1:0]  req_tag;
    logic [LINE_W-1:0] req_line;
    logic              unused_addr_lsb;

    assign req_word        = addr_i[2 +: WO_W];
    assign req_index       = addr_i[2 + WO_W +: IX_W];
    assign req_tag         = addr_i[XLEN-1 -: TAG_W];
    assign req_line        = addr_i[XLEN-1 -: LINE_W];
    assign unused_addr_lsb = ^addr_i[1:0];

    // Refill controller interface.
    logic              refill_busy;
    logic              hit;
    logic              req_miss;
    logic [LINE_W-1:0] fill_line;
    logic [WO_W-1:0]   fill_word;
    logic [IX_W-1:0]   fill_index;
    logic [TAG_W-1:0]  fill_tag;
    logic              data_we;
    logic              tag_we;
    logic              valid_set;

    assign fill_index = fill_line[IX_W-1:0];
    assign fill_tag   = fill_line[LINE_W-1:IX_W];

    // Hit compare; an invalidate in the same cycle suppresses both hit and miss.
    assign hit      = valid_q[req_index] && (tag_q[req_index] == req_tag);
    assign req_miss = validReq_i && !hit && !invalidate_i;
    assign ready_o  = !refill_busy && validReq_i && hit && !invalidate_i;
    assign instr_o  = ready_o ? data_q[{req_index, req_word}] : INSTR_NOP;

    icache_refill_ctrl #(
        .WO_W   (WO_W),
        .LINE_W (LINE_W)
    ) u_refill_ctrl (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_miss_i   (req_miss),
        .miss_line_i  (req_line),
        .invalidate_i (invalidate_i),
        .mem_ready_i  (memReady_i),
        .busy_o       (refill_busy),
        .mem_req_o    (memReq_o),
        .mem_addr_o   (memAddr_o),
        .fill_line_o  (fill_line),
        .fill_word_o  (fill_word),
        .data_we_o    (data_we),
        .tag_we_o     (tag_we),
        .valid_set_o  (valid_set)
    );

    // Valid-bit update: invalidate wins over a completing refill.
    always_comb begin
        valid_d = valid_q;
        if (valid_set) begin
            valid_d[fill_index] = 1'b1;
        end
        if (invalidate_i) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays (not reset).
    always_ff @(posedge clk_i) begin
        if (data_we && !rst_i) begin
            data_q[{fill_index, fill_word}] <= memData_i;
        end
        if (tag_we && !rst_i) begin
            tag_q[fill_index] <= fill_tag;
        end
    end

endmodule : icache_responder

// File: tb/tb_icache_responder.sv
// ---------------------------------------------------------------------------
// tb_icache_responder
// Directed scenarios followed by randomized traffic. A reference model of
// the cache (which line each set holds, plus the queue of word addresses
// still owed by the refill in flight) predicts every cycle's outputs; the
// prediction goes into a scoreboard queue that a negedge monitor drains.
// ---------------------------------------------------------------------------
module tb_icache_responder;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam int unsigned NSETS   = 16;
    localparam int unsigned INV_LN  = 32'hFFFF_FFFF;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        validReq_i;
    logic [31:0] addr_i;
    logic        invalidate_i;
    logic        ready_o;
    logic [31:0] instr_o;
    logic        memReq_o;
    logic [31:0] memAddr_o;
    logic        memReady_i;
    logic [31:0] memData_i;

    always #5 clk_i = ~clk_i;

    icache_responder #(
        .SETS        (16),
        .BLOCK_WORDS (4),
        .INSTR_NOP   (32'h0000_0013)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .validReq_i   (validReq_i),
        .addr_i       (addr_i),
        .invalidate_i (invalidate_i),
        .ready_o      (ready_o),
        .instr_o      (instr_o),
        .memReq_o     (memReq_o),
        .memAddr_o    (memAddr_o),
        .memReady_i   (memReady_i),
        .memData_i    (memData_i)
    );

    typedef struct {
        bit          chk;
        int          cyc;
        logic        ready;
        logic [31:0] instr;
        logic        mreq;
        logic [31:0] maddr;
    } exp_t;

    exp_t        sb[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;

    // Backing memory: preloaded words, otherwise a fixed hash of the address.
    logic [31:0] pre_mem [int unsigned];

    // Reference model state.
    int unsigned model_line [NSETS];
    int unsigned pend[$];
    int unsigned ref_line;
    bit          aborted;
    bit          model_known;

    // Sampled DUT outputs of the most recent step, for directed checks.
    logic        s_ready, s_mreq;
    logic [31:0] s_instr, s_maddr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (pre_mem.exists(w)) return pre_mem[w];
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(NSETS); i++) model_line[i] = INV_LN;
    endtask

    // One clock cycle: drive inputs, predict outputs, advance the model.
    task automatic step(input bit vreq, input logic [31:0] a, input bit inv,
                        input bit mrdy, input bit rst);
        exp_t        e;
        int unsigned line;
        int unsigned idx;
        int unsigned dummy;
        bit          hit;
        @(posedge clk_i);
        #1;
        cyc++;
        validReq_i   = vreq;
        addr_i       = a;
        invalidate_i = inv;
        memReady_i   = mrdy;
        rst_i        = rst;
        memData_i    = mem_word(memAddr_o);

        line  = a >> 4;
        idx   = line % NSETS;
        hit   = 1'b0;
        e.chk = model_known && !rst;
        e.cyc = cyc;
        if (pend.size() > 0) begin
            e.ready = 1'b0;
            e.instr = NOP;
            e.mreq  = 1'b1;
            e.maddr = pend[0];
        end else begin
            hit     = (model_line[idx] == line);
            e.mreq  = 1'b0;
            e.maddr = 32'h0;
            e.ready = vreq && hit && !inv;
            e.instr = e.ready ? mem_word(a) : NOP;
        end
        sb.push_back(e);

        if (rst) begin
            model_clear();
            pend.delete();
            aborted     = 1'b0;
            model_known = 1'b1;
        end else if (pend.size() > 0) begin
            if (inv) begin
                aborted = 1'b1;
                model_clear();
            end
            if (mrdy) begin
                dummy = pend.pop_front();
                if (pend.size() == 0) begin
                    if (!aborted) model_line[ref_line % NSETS] = ref_line;
                    aborted = 1'b0;
                end
            end
        end else begin
            if (inv) begin
                model_clear();
            end else if (vreq && !hit) begin
                ref_line = line;
                aborted  = 1'b0;
                for (int w = 0; w < 4; w++) pend.push_back((line << 4) | (w << 2));
            end
        end

        #2;
        s_ready = ready_o;
        s_instr = instr_o;
        s_mreq  = memReq_o;
        s_maddr = memAddr_o;
    endtask

    // Request one address until it is served; memReady every 'period' cycles.
    task automatic fill(input logic [31:0] a, input int period,
                        output int rdy_k, output int acc, output int last_acc);
        bit mrdy;
        rdy_k    = -1;
        acc      = 0;
        last_acc = -1;
        for (int k = 0; k < 64; k++) begin
            mrdy = ((k % period) == (period - 1));
            step(1'b1, a, 1'b0, mrdy, 1'b0);
            if (s_mreq && mrdy) begin
                acc++;
                last_acc = k;
            end
            if (s_ready) begin
                rdy_k = k;
                break;
            end
        end
        check($sformatf("fill_served_%0h", a), 32'(s_ready), 32'd1);
    endtask

    // Scoreboard monitor.
    always @(negedge clk_i) begin
        exp_t m;
        if (sb.size() > 0) begin
            m = sb.pop_front();
            if (m.chk) begin
                check($sformatf("ready@%0d", m.cyc), 32'(ready_o), 32'(m.ready));
                check($sformatf("instr@%0d", m.cyc), instr_o, m.instr);
                check($sformatf("memReq@%0d", m.cyc), 32'(memReq_o), 32'(m.mreq));
                check($sformatf("memAddr@%0d", m.cyc), memAddr_o, m.maddr);
            end
        end
    end

    initial begin
        int rk, acc, la;
        logic [31:0] a;
        logic [23:0] tg;
        logic [3:0]  ix;

        rst_i        = 1'b1;
        validReq_i   = 1'b0;
        addr_i       = 32'h0;
        invalidate_i = 1'b0;
        memReady_i   = 1'b0;
        memData_i    = 32'h0;
        model_known  = 1'b0;
        aborted      = 1'b0;
        ref_line     = 0;
        model_clear();
        for (int n = 0; n < 4; n++) pre_mem[32'h100 + 4 * n] = 32'hA0 + n;

        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Reset state.
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_instr", s_instr, NOP);
        check("rst_memReq", 32'(s_mreq), 32'd0);
        check("rst_memAddr", s_maddr, 32'h0);

        // Cold miss on 0x100, memory ready every cycle.
        fill(32'h100, 1, rk, acc, la);
        check("s1_latency", rk, 5);
        check("s1_accepts", acc, 4);
        check("s1_instr", s_instr, 32'hA0);

        // Same-line hit.
        step(1'b1, 32'h108, 1'b0, 1'b0, 1'b0);
        check("s2_ready", 32'(s_ready), 32'd1);
        check("s2_instr", s_instr, 32'hA2);
        check("s2_memReq", 32'(s_mreq), 32'd0);

        // Slow memory: one accept every third cycle.
        fill(32'h200, 3, rk, acc, la);
        check("s3_accepts", acc, 4);
        check("s3_ready_after_last", rk, la + 1);
        check("s3_latency", rk, 12);

        // Conflict: 0x100 and 0x500 share a set.
        fill(32'h100, 1, rk, acc, la);
        check("s4_refetch_latency", rk, 5);
        fill(32'h500, 1, rk, acc, la);
        check("s4_conflict_latency", rk, 5);
        step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        check("s4_evicted_ready", 32'(s_ready), 32'd0);
        step(1'b1, 32'h100, 1'b0, 1'b1, 1'b0);
        check("s4_refill_req", 32'(s_mreq), 32'd1);
        check("s4_refill_addr", s_maddr, 32'h100);
        fill(32'h100, 1, rk, acc, la);

        // Invalidate while the second word of a refill is outstanding.
        acc = 0;
        for (int k = 0; k < 7; k++) begin
            step(1'b1, 32'h300, (k == 2), 1'b1, 1'b0);
            if (k >= 1 && k <= 4 && s_mreq) acc++;
            if (k == 5) begin
                check("s5_after_ready", 32'(s_ready), 32'd0);
                check("s5_after_memReq", 32'(s_mreq), 32'd0);
            end
            if (k == 6) begin
                check("s5_rerefill_req", 32'(s_mreq), 32'd1);
                check("s5_rerefill_addr", s_maddr, 32'h300);
            end
        end
        check("s5_accepts", acc, 4);
        fill(32'h300, 1, rk, acc, la);

        // Reset in the middle of a refill.
        fill(32'h100, 1, rk, acc, la);
        step(1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
        check("s6_pre_hit", 32'(s_ready), 32'd1);
        check("s6_pre_instr", s_instr, 32'hA1);
        step(1'b1, 32'h600, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h600, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h600, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h600, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        check("s6_post_memReq", 32'(s_mreq), 32'd0);
        check("s6_post_ready", 32'(s_ready), 32'd0);
        step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        check("s6_miss_req", 32'(s_mreq), 32'd1);
        check("s6_miss_addr", s_maddr, 32'h100);
        fill(32'h100, 1, rk, acc, la);

        // Randomized traffic over a small tag pool to force hits and conflicts.
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0: tg = 24'h00_0000;
                1: tg = 24'h00_0001;
                2: tg = 24'h80_0000;
                default: tg = 24'hFF_FFFF;
            endcase
            ix = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3))
                                             : 4'($urandom_range(0, 15));
            a  = {tg, ix, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            step(($urandom_range(0, 9) < 8), a, ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 299) == 0));
        end

        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk_i);
        @(posedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_icache_responder
